// File: rtl/router_merge_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : router_merge_arbiter
// Description : Five-to-one round-robin merge of router link/core packets into
//               a single registered output stage. Reports the winning port in
//               the same 3-bit code used by the path-computation split stage.
//               Optional per-port saturating packet counters are enabled by
//               defining MERGE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module router_merge_arbiter #(
  parameter int WIDTH = 11,
  parameter int ID_W  = 3,
  parameter int NPORT = 5
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic [NPORT-1:0]       in_valid,
  input  logic [NPORT*WIDTH-1:0] in_data,
  input  logic [NPORT*ID_W-1:0]  in_id,
  output logic [NPORT-1:0]       in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [ID_W-1:0]        out_src_id,
  output logic [2:0]             out_port,
  input  logic                   out_ready
`ifdef MERGE_STATS_EN
  ,
  output logic [NPORT*16-1:0]    pkt_cnt
`endif
);

  // Round-robin pointer: port that has first priority this cycle.
  logic [2:0]       rr_ptr;
  logic             can_load;
  logic             win_found;
  logic [2:0]       win_idx;
  logic [3:0]       cand;
  logic             xfer;

  logic [WIDTH-1:0] data_arr [NPORT];
  logic [ID_W-1:0]  id_arr   [NPORT];

  // Unpack flat input buses into per-port arrays for readable muxing.
  generate
    for (genvar i = 0; i < NPORT; i++) begin : g_unpack
      assign data_arr[i] = in_data[i*WIDTH +: WIDTH];
      assign id_arr[i]   = in_id[i*ID_W +: ID_W];
    end
  endgenerate

  // The output register can accept a new packet when empty or draining.
  assign can_load = !out_valid || out_ready;

  // Round-robin search starting at rr_ptr, wrapping 4 -> 0; first valid wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 4'd0;
    for (int k = 0; k < NPORT; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(NPORT)) begin
        cand = cand - 4'(NPORT);
      end
      if (!win_found && in_valid[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  // Grant only the winner, only when the output can take it and not in reset.
  always_comb begin
    in_ready = '0;
    if (!RESET && win_found && can_load) begin
      in_ready[win_idx] = 1'b1;
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Output register and pointer update; a stalled winner keeps priority
  // because rr_ptr only advances on an accepted transfer.
  always_ff @(posedge clk) begin
    if (RESET) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src_id <= '0;
      out_port   <= 3'd0;
      rr_ptr     <= 3'd0;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= data_arr[win_idx];
      out_src_id <= id_arr[win_idx];
      out_port   <= win_idx;
      rr_ptr     <= (win_idx == 3'(NPORT - 1)) ? 3'd0 : win_idx + 3'd1;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef MERGE_STATS_EN
  // Per-port accepted-packet counters, saturating at all-ones.
  generate
    for (genvar i = 0; i < NPORT; i++) begin : g_stats
      logic [15:0] cnt;
      // Count port-i transfers; hold at 16'hFFFF once reached.
      always_ff @(posedge clk) begin
        if (RESET) begin
          cnt <= 16'd0;
        end else if (in_valid[i] && in_ready[i] && (cnt != 16'hFFFF)) begin
          cnt <= cnt + 16'd1;
        end
      end
      assign pkt_cnt[i*16 +: 16] = cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
